// File: rtl/read_ptr_ctrl.sv
// Read-side pointer control for an asynchronous FIFO.
// It synchronizes the Gray write pointer into rclk and keeps the binary and
// Gray read pointers. It also produces registered empty, almost-empty and
// occupancy flags, and a sticky underflow error.
module read_ptr_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int SYNC_STAGES = 2    // legal range 2..4
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wptr_gray,
    input  logic [ADDR_W:0]   aempty_thresh,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              rempty,
    output logic              raempty,
    output logic [ADDR_W:0]   rcount,
    output logic              underflow
);

    logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
    logic [ADDR_W:0] wq_gray;
    logic [ADDR_W:0] wq_bin;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] rgray_next;
    logic [ADDR_W:0] count_next;
    logic            rd_fire;

    assign wq_gray = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        wq_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            wq_bin[i] = ^(wq_gray >> i);
        end
    end

    // Next-state pointer and occupancy math. A read is allowed only when the
    // FIFO is not empty, so a blocked read never moves the pointer.
    always_comb begin
        rd_fire    = rd_en & ~rempty;
        rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_fire};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        count_next = wq_bin - rbin_next;
    end

    assign raddr = rbin[ADDR_W-1:0];

    // Write-pointer synchronizer chain; reset flushes all stages
    always_ff @(posedge rclk) begin
        if (rrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
        end
    end

    // Read pointers and flags. They all compare the post-read pointer
    // against the freshly synchronized write pointer.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
            raempty   <= 1'b1;
            rcount    <= '0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == wq_gray);
            raempty   <= (count_next <= aempty_thresh);
            rcount    <= count_next;
        end
    end

    // Sticky underflow. A new underflow in the same cycle beats the clear.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            underflow <= 1'b0;
        end else begin
            underflow <= (rd_en & rempty) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Self-checking bench for read_ptr_ctrl.
// A queue-based delay-line model predicts every output at every cycle.
module tb_read_ptr_ctrl;

    localparam int AW   = 4;
    localparam int SYNC = 2;
    localparam int MODV = 1 << (AW + 1);   // pointer modulus (32)
    localparam int DEPTH = 1 << AW;        // 16

    logic          rclk = 1'b0;
    logic          rrst;
    logic          rd_en;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   aempty_thresh;
    logic          clr_err;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr_gray;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          underflow;

    read_ptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SYNC)) dut (
        .rclk(rclk), .rrst(rrst), .rd_en(rd_en), .wptr_gray(wptr_gray),
        .aempty_thresh(aempty_thresh), .clr_err(clr_err), .raddr(raddr),
        .rptr_gray(rptr_gray), .rempty(rempty), .raempty(raempty),
        .rcount(rcount), .underflow(underflow)
    );

    always #5 rclk = ~rclk;

    int errs = 0;
    int checks = 0;

    // Model state: read count, write count, flags and a delay line of write samples
    int wp;
    int m_rd, m_cnt;
    bit m_empty, m_aempty, m_under;
    int pipe[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return (v >> 1) ^ v;
    endfunction

    task automatic set_wp(input int v);
        wp = v % MODV;
        wptr_gray = to_gray(wp);
    endtask

    task automatic model_reset();
        m_rd = 0; m_cnt = 0; m_empty = 1; m_aempty = 1; m_under = 0;
        pipe = {};
        repeat (SYNC) pipe.push_back(0);
    endtask

    // One clock: update the model at the rising edge, then check at the falling edge
    task automatic tick();
        int wq;
        bit fire, und;
        @(posedge rclk);
        if (rrst) begin
            model_reset();
        end else begin
            wq = pipe.pop_front();
            pipe.push_back(wp);
            fire = rd_en && !m_empty;
            und  = rd_en && m_empty;
            m_rd = (m_rd + int'(fire)) % MODV;
            m_cnt = (wq + MODV - m_rd) % MODV;
            m_empty = (m_cnt == 0);
            m_aempty = (m_cnt <= int'(aempty_thresh));
            m_under = und || (m_under && !clr_err);
        end
        @(negedge rclk);
        chk("raddr", 32'(raddr), 32'(m_rd % DEPTH));
        chk("rptr_gray", 32'(rptr_gray), 32'(to_gray(m_rd)));
        chk("rempty", 32'(rempty), 32'(m_empty));
        chk("raempty", 32'(raempty), 32'(m_aempty));
        chk("rcount", 32'(rcount), 32'(m_cnt));
        chk("underflow", 32'(underflow), 32'(m_under));
    endtask

    task automatic do_reset(input int cycles);
        rrst = 1'b1;
        repeat (cycles) tick();
        rrst = 1'b0;
    endtask

    logic [AW:0] prev_gray;

    initial begin
        rrst = 1'b1; rd_en = 1'b0; clr_err = 1'b0; aempty_thresh = '0;
        set_wp(0);
        model_reset();

        // Reset with write pointer at binary 2; flags hold while in reset
        set_wp(2);
        do_reset(3);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_raempty", 32'(raempty), 32'd1);
        chk("rst_rcount", 32'(rcount), 32'd0);
        repeat (2) tick();
        chk("sync_lat_empty", 32'(rempty), 32'd1);
        tick();
        chk("sync_lat_rempty", 32'(rempty), 32'd0);
        chk("sync_lat_rcount", 32'(rcount), 32'd2);

        // Three entries, four reads: the last read underflows and the pointer holds
        do_reset(1);
        set_wp(3);
        repeat (3) tick();
        rd_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_raddr", 32'(raddr), 32'(k < 3 ? k : 3));
        end
        chk("drain_empty", 32'(rempty), 32'd1);
        chk("drain_underflow", 32'(underflow), 32'd1);

        // A clear during a fresh underflow loses; a clear without one wins
        clr_err = 1'b1;
        tick();
        chk("clr_vs_set", 32'(underflow), 32'd1);
        rd_en = 1'b0;
        tick();
        chk("clr_ok", 32'(underflow), 32'd0);
        clr_err = 1'b0;

        // Full view and almost-empty threshold while draining
        aempty_thresh = 5'd4;
        do_reset(1);
        set_wp(16);
        repeat (3) tick();
        chk("full_rcount", 32'(rcount), 32'd16);
        chk("full_rempty", 32'(rempty), 32'd0);
        rd_en = 1'b1;
        repeat (14) begin
            tick();
            chk("aempty_rule", 32'(raempty), 32'(rcount <= 5'd4));
        end
        rd_en = 1'b0;

        // Reset in the middle of a drain
        aempty_thresh = 5'd0;
        do_reset(1);
        set_wp(10);
        repeat (3) tick();
        rd_en = 1'b1;
        repeat (7) tick();
        chk("middrain_raddr", 32'(raddr), 32'd7);
        rrst = 1'b1;
        tick();
        chk("mrst_raddr", 32'(raddr), 32'd0);
        chk("mrst_empty", 32'(rempty), 32'd1);
        rrst = 1'b0;
        repeat (3) tick();
        chk("mrst_recover", 32'(rcount), 32'd10);
        rd_en = 1'b0;

        // Randomized traffic across several pointer wraps
        aempty_thresh = 5'($urandom_range(0, 16));
        do_reset(1);
        prev_gray = rptr_gray;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) != 0 && ((wp + MODV - m_rd) % MODV) < DEPTH)
                set_wp(wp + 1);
            rd_en = 1'($urandom_range(0, 1));
            clr_err = ($urandom_range(0, 7) == 0);
            tick();
            chk("gray_one_bit", 32'($countones(rptr_gray ^ prev_gray) <= 1), 32'd1);
            prev_gray = rptr_gray;
        end
        chk("wrapped", 32'(wp > 0 || m_rd > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/read_ptr_ctrl.md
READ_PTR_CTRL -- requirements
Module: read_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, FIFO address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, write-pointer synchronizer depth; legal range 2..4.
REQ-003 SHALL have port rclk  input  1  read-domain clock; the only clock; all flops on its rising edge.
REQ-004 SHALL have port rrst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rd_en  input  1  read request from the consumer.
REQ-006 SHALL have port wptr_gray  input  ADDR_W+1  Gray write pointer from the write domain, asynchronous to rclk.
REQ-007 SHALL have port aempty_thresh  input  ADDR_W+1  almost-empty threshold in entries; quasi-static.
REQ-008 SHALL have port clr_err  input  1  clears the sticky underflow flag.
REQ-009 SHALL have port raddr  output  ADDR_W  RAM read address.
REQ-010 SHALL have port rptr_gray  output  ADDR_W+1  registered Gray read pointer, sent to the write domain.
REQ-011 SHALL have port rempty  output  1  registered empty flag.
REQ-012 SHALL have port raempty  output  1  registered almost-empty flag.
REQ-013 SHALL have port rcount  output  ADDR_W+1  registered occupancy, read-domain view.
REQ-014 SHALL have port underflow  output  1  sticky read-while-empty error.

Function
REQ-015 SHALL pass wptr_gray through a SYNC_STAGES-deep flop chain; only the last stage (wq_gray) is used.
REQ-016 SHALL convert wq_gray to binary wq_bin combinationally (MSB copy, then XOR-prefix toward the LSB).
REQ-017 SHALL qualify a read as rd_fire = rd_en AND NOT rempty; rd_en while rempty SHALL NOT move the pointer.
REQ-018 SHALL compute rbin_next = rbin + rd_fire, modulo 2^(ADDR_W+1); the wrap from all-ones to 0 SHALL toggle the pointer MSB.
REQ-019 SHALL compute rgray_next = (rbin_next >> 1) XOR rbin_next; each edge SHALL register rbin <= rbin_next and rptr_gray <= rgray_next.
REQ-020 SHALL drive raddr = rbin[ADDR_W-1:0] directly from the register, with no combinational path from rd_en.
REQ-021 SHALL register rempty <= (rgray_next == wq_gray), so that the last read asserts rempty on the next edge.
REQ-022 SHALL register rcount <= (wq_bin - rbin_next) mod 2^(ADDR_W+1); this value ranges 0..2^ADDR_W.
REQ-023 SHALL register raempty <= (count_next <= aempty_thresh), where count_next is the value loaded into rcount.
REQ-024 With aempty_thresh = 0, SHALL make raempty equal to rempty.
REQ-025 SHALL set underflow on any edge where rd_en AND rempty; it SHALL stay set until an edge with clr_err = 1 and no new underflow; set SHALL win over a simultaneous clear.
REQ-026 SHALL treat a write-pointer advance as visible at rempty/rcount exactly SYNC_STAGES+1 rclk edges after it appears at wptr_gray; rempty is pessimistic and SHALL never falsely deassert.
REQ-027 For simultaneous read and write-pointer arrival, SHALL use the post-read rbin_next and the newly synchronized wq_gray in the same compare, with no special-casing.

Reset
REQ-028 On rrst = 1 at a rising edge, SHALL clear rbin, rptr_gray, rcount and all synchronizer stages to 0, set rempty = 1, set raempty = 1, and clear underflow = 0.
REQ-029 Reset asserted mid-operation SHALL override rd_en and clr_err in that cycle; outputs SHALL hold their reset values while rrst = 1.
REQ-030 The first rd_fire SHALL be possible only after rrst deasserts and a nonzero wptr_gray has propagated per REQ-026.

Verification (ADDR_W=4, SYNC_STAGES=2)
REQ-031 Reset with wptr_gray held at 5'b00011 -> rempty=1, raempty=1, rcount=0 during reset; 3 edges after release: rempty=0, rcount=2.
REQ-032 Write pointer at bin 3; rd_en=1 for 4 cycles -> raddr steps 0,1,2,3; rempty rises after the third read; the fourth rd_en sets underflow, and raddr stays 3.
REQ-033 Wrap test: 40 write/read pairs -> rptr_gray sequence differs by exactly one bit per step; pointer MSB toggles after raddr 15->0; rempty tracks correctly across the wrap.
REQ-034 Full view: wptr bin 16, rbin 0 -> rcount=16, rempty=0; with aempty_thresh=4, drain to count 4 -> raempty=1 exactly when rcount<=4.
REQ-035 Underflow asserted and clr_err=1 while rd_en=1 with rempty=1 -> underflow stays 1; next cycle clr_err=1 with rd_en=0 -> underflow=0.
REQ-036 Assert rrst mid-drain (rbin=7) -> next edge: rbin=0, rempty=1, underflow=0; synchronizer flushed, so rcount recovers after SYNC_STAGES+1 edges.
